// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - asynchronous serial receiver, start/DATA_BITS LSB-first/stop framing
// Two-flop input sync, mid-bit sampling, BREAK state blocks re-arm on a held-low line.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
    logic                   meta_q, meta_d;
    logic                   rxd_s_q, rxd_s_d;

    always_comb begin
        meta_d  = rxd;
        rxd_s_d = meta_q;
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again at mid-start-bit was a glitch.
                    state_d = rxd_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d                = '0;
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rxd_s_q;
                    bit_d                = bit_q + 1'b1;
                    if (bit_q == BITS_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rxd_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            meta_q  <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            meta_q  <= meta_d;
            rxd_s_q <= rxd_s_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed self-checking bench for serial_rx
module tb_serial_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, busy;

    serial_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_hi = 0;
    int vq_cyc[$];
    logic [7:0] vq_dat[$];
    int fq_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vq_cyc.push_back(cyc);
            vq_dat.push_back(data_out);
        end
        if (frame_err) fq_cyc.push_back(cyc);
        if (valid && frame_err) both_hi++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves rxd at the stop-bit level; t0 is the cycle count just before the line falls.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
        rxd = 1'b0;
        t0  = cyc;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(16);
        end
        rxd = stop;
        idle(16);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_v;
        logic       exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0, t1, nv, nf, bcount;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};
        vecs[3] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
        vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};

        // Reset
        idle(2);
        chk("reset data_out", int'(data_out), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b0;
        idle(10);

        foreach (vecs[k]) begin
            nv = vq_cyc.size();
            nf = fq_cyc.size();
            send_frame(vecs[k].data, vecs[k].stop, t0);
            rxd = 1'b1;
            idle(20);
            chk($sformatf("vec%0d valid count", k), vq_cyc.size() - nv, int'(vecs[k].exp_v));
            chk($sformatf("vec%0d ferr count", k), fq_cyc.size() - nf, int'(vecs[k].exp_f));
            chk($sformatf("vec%0d data_out", k), int'(data_out), int'(vecs[k].exp_data));
            chk($sformatf("vec%0d busy idle", k), int'(busy), 0);
            if (vecs[k].exp_v && vq_cyc.size() > nv)
                chk($sformatf("vec%0d valid latency", k), vq_cyc[$] - t0 - 1, 154);
            if (vecs[k].exp_f && fq_cyc.size() > nf)
                chk($sformatf("vec%0d ferr latency", k), fq_cyc[$] - t0 - 1, 154);
        end

        // Start-bit glitch
        nv = vq_cyc.size();
        nf = fq_cyc.size();
        bcount = 0;
        rxd = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 3) rxd = 1'b1;
            @(negedge clk);
            if (busy) bcount++;
        end
        chk("glitch busy cycles", bcount, 8);
        chk("glitch pulses", (vq_cyc.size() - nv) + (fq_cyc.size() - nf), 0);

        // Bad stop bit, then line held low
        nv = vq_cyc.size();
        nf = fq_cyc.size();
        send_frame(8'h3C, 1'b0, t0);
        bcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcount++;
        end
        chk("break busy held", bcount, 40);
        chk("break ferr count", fq_cyc.size() - nf, 1);
        chk("break no valid", vq_cyc.size() - nv, 0);
        chk("break data_out kept", int'(data_out), 8'hA5);
        rxd = 1'b1;
        idle(6);
        chk("break released busy", int'(busy), 0);
        chk("break single ferr", fq_cyc.size() - nf, 1);
        idle(10);

        // Back-to-back frames, no idle time
        nv = vq_cyc.size();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        rxd = 1'b1;
        idle(20);
        chk("b2b valid count", vq_cyc.size() - nv, 2);
        if (vq_cyc.size() - nv == 2) begin
            chk("b2b first data", int'(vq_dat[nv]), 8'h00);
            chk("b2b second data", int'(vq_dat[nv+1]), 8'hFF);
            chk("b2b spacing", vq_cyc[nv+1] - vq_cyc[nv], 160);
            chk("b2b first latency", vq_cyc[nv] - t0 - 1, 154);
        end
        chk("b2b data_out", int'(data_out), 8'hFF);

        // Reset in the middle of data bit 4
        nv = vq_cyc.size();
        nf = fq_cyc.size();
        rxd = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            idle(16);
        end
        rxd = 1'b0;
        idle(8);
        chk("midframe busy before rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst data_out", int'(data_out), 0);
        chk("midrst valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        idle(200);
        chk("midrst no pulses", (vq_cyc.size() - nv) + (fq_cyc.size() - nf), 0);
        send_frame(8'h5A, 1'b1, t0);
        rxd = 1'b1;
        idle(20);
        chk("post-rst valid count", vq_cyc.size() - nv, 1);
        chk("post-rst data_out", int'(data_out), 8'h5A);
        if (vq_cyc.size() - nv == 1)
            chk("post-rst latency", vq_cyc[$] - t0 - 1, 154);

        chk("valid and frame_err overlap", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
